// File: rtl/div_nonrestoring_seq.sv
// Sequential unsigned non-restoring divider: one quotient bit per cycle,
// start/busy/done handshake, divide-by-zero flagged with saturated quotient.
module div_nonrestoring_seq #(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] dividend,
  input  logic [B_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [A_W-1:0] quotient,
  output logic [B_W-1:0] remainder,
  output logic           dbz
);

  localparam int CNT_W = $clog2(A_W + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [B_W:0]   p_q, p_d;
  logic [A_W-1:0] q_q, q_d;
  logic [B_W-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           dbz_flag_q, dbz_flag_d;
  logic [A_W-1:0] quotient_q, quotient_d;
  logic [B_W-1:0] remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  logic [B_W:0]   d_ext, p_sh, p_iter, p_fix;

  // P is kept modulo 2^(B_W+1); its true value always lies in [-D, D).
  assign d_ext  = {1'b0, d_q};
  assign p_sh   = {p_q[B_W-1:0], q_q[A_W-1]};
  assign p_iter = p_q[B_W] ? (p_sh + d_ext) : (p_sh - d_ext);
  assign p_fix  = p_q[B_W] ? (p_q + d_ext) : p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dbz_flag_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dbz_flag_q  <= dbz_flag_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dbz_flag_d  = dbz_flag_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          d_d        = divisor;
          q_d        = dividend;
          p_d        = '0;
          cnt_d      = CNT_W'(A_W);
          dbz_flag_d = (divisor == '0);
          // Divide-by-zero still passes through FIX so its done lands two cycles out.
          state_d    = (divisor == '0) ? FIX : ITER;
        end
      end
      ITER: begin
        p_d   = p_iter;
        q_d   = {q_q[A_W-2:0], ~p_iter[B_W]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        p_d         = p_fix;
        quotient_d  = dbz_flag_q ? '1 : q_q;
        remainder_d = dbz_flag_q ? '0 : p_fix[B_W-1:0];
        dbz_d       = dbz_flag_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ITER, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default: ;
    endcase
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule
